instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Instruction-issue front end for the datapath decoder. It takes field-level instruction requests (opcode, destination, source/ext-opcode or 8-bit immediate) over a valid/ready handshake and packs them into 16-bit instruction words.
- Words are buffered in a small FIFO and issued one per cycle on a registered Instruction output that feeds the decoder's Instruction input directly.
- When nothing is ready to issue, a harmless NOP word is driven instead, so the decoder (which executes every cycle) never sees garbage.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- NOP_WORD, 16'h00D0, word driven when idle/stalled (MOV R0,R0: op 0000, ext 1101).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  encoder can accept the request this cycle.
- in_imm  in  1  1 = immediate format, 0 = register format.
- in_op  in  4  becomes Instruction[15:12].
- in_rdest  in  4  becomes Instruction[11:8].
- in_ext  in  4  ext opcode, Instruction[7:4] (register format only).
- in_rsrc  in  4  source register, Instruction[3:0] (register format only).
- in_imm8  in  8  immediate, Instruction[7:0] (immediate format only).
- Stall  in  1  hold off issue; NOP is driven and the FIFO is not popped.
- Flush  in  1  synchronous discard of all buffered entries.
- Instruction  out  16  registered instruction word to the decoder.
- InstrValid  out  1  Instruction holds a real entry, not NOP_WORD.
- Level  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Encoding is pure field packing, with no legality check:
  - register format: {in_op, in_rdest, in_ext, in_rsrc}
  - immediate format: {in_op, in_rdest, in_imm8}
- Reset (async, high):
  - write/read pointers and Level go to 0.
  - Instruction = NOP_WORD, InstrValid = 0.
  - in_ready is forced 0 while Reset is high.
- in_ready = !Reset && !Flush && (Level != DEPTH). It depends only on registered state plus Reset/Flush, never on the same-cycle pop.
- Push: in_valid && in_ready at a rising edge writes the encoded word at the write pointer, and the pointer wraps modulo DEPTH. A request with in_valid low is ignored. Fields only need to be stable while in_valid && in_ready.
- Issue register update, every rising edge, in priority order:
  1. Flush = 1: pointers and Level go to 0; Instruction = NOP_WORD, InstrValid = 0; any same-cycle push is dropped (in_ready is already 0).
  2. Stall = 0 and Level > 0: pop the head into Instruction, InstrValid = 1; the read pointer wraps modulo DEPTH.
  3. Otherwise: Instruction = NOP_WORD, InstrValid = 0.
- Level changes by +1 on push only, −1 on pop only, and is unchanged when push and pop happen together.
- There is no empty bypass, so latency from the accepting edge to Instruction is 2 edges. A request accepted at edge N is visible after edge N+1 if there is no stall.
- Throughput is 1 word per cycle sustained: push and pop can occur in the same cycle, including with Level = DEPTH−1.
- Full: a push is only possible when Level < DEPTH. A pop in the same cycle as full does not raise in_ready combinationally.
- Stall overrides issue but not acceptance; pushes continue until full.
- Reset mid-stream discards all entries immediately (asynchronously).

Optional Feature:
- Macro: INSTR_ENCODER_REPEAT_EN.
- With the macro defined:
  - adds input in_repeat[3:0], stored per entry;
  - the head entry is issued in_repeat+1 consecutive non-stalled cycles before it pops;
  - a repeat counter counts down only on non-stalled issue cycles, and Stall freezes it;
  - InstrValid = 1 on every repeat;
  - Level decrements only on the final issue;
  - Flush and Reset clear the counter.
- Without the macro: the port is absent and every entry issues exactly once.

Test Plan:
- Reset then idle -> Instruction = 16'h00D0, InstrValid = 0, in_ready = 1, Level = 0.
- Push register ADD (op 0, rdest 3, ext 5, rsrc 7) at edge N -> Instruction = 16'h0357 and InstrValid = 1 after edge N+1, then NOP_WORD.
- Push immediate (imm = 1, op 5, rdest 2, imm8 8'hF0) while Stall = 1 for 3 cycles -> NOP held, Level = 1; Stall drops -> 16'h52F0 issued next edge.
- With Stall = 1, push DEPTH = 4 words -> Level = 4, in_ready = 0, and a fifth in_valid is not accepted. Release Stall -> four words issue in order on consecutive cycles, and pointers wrap correctly on a refill.
- Level = 3, Flush asserted together with a valid push -> next edge Level = 0, push dropped, Instruction = NOP_WORD. Separately, assert Reset asynchronously between edges -> outputs return to reset values immediately.
- (INSTR_ENCODER_REPEAT_EN) push 16'h1234 with in_repeat = 2 and a Stall pulse mid-sequence -> word issued exactly 3 non-stalled cycles, NOP during the stall, then Level decrements.

Source files
------------

// File: rtl/instr_encoder.sv
// Packs field-level instruction requests into 16-bit words, buffers them in a FIFO and
// issues one registered word per cycle (NOP_WORD when idle). Optional: INSTR_ENCODER_REPEAT_EN.
module instr_encoder #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] NOP_WORD = 16'h00D0
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_imm,
  input  logic [3:0]               in_op,
  input  logic [3:0]               in_rdest,
  input  logic [3:0]               in_ext,
  input  logic [3:0]               in_rsrc,
  input  logic [7:0]               in_imm8,
`ifdef INSTR_ENCODER_REPEAT_EN
  input  logic [3:0]               in_repeat,
`endif
  input  logic                     Stall,
  input  logic                     Flush,
  output logic [15:0]              Instruction,
  output logic                     InstrValid,
  output logic [$clog2(DEPTH):0]   Level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  function automatic logic [15:0] pack_word(
    input logic       imm,
    input logic [3:0] op,
    input logic [3:0] rdest,
    input logic [3:0] ext,
    input logic [3:0] rsrc,
    input logic [7:0] imm8
  );
    if (imm) return {op, rdest, imm8};
    else     return {op, rdest, ext, rsrc};
  endfunction

  logic [15:0]   mem_p0 [DEPTH];
  logic [15:0]   word_p0;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic [15:0]   instr_p1;
  logic          vld_p1;
  logic          push;
  logic          issue;
  logic          pop;

  assign word_p0  = pack_word(in_imm, in_op, in_rdest, in_ext, in_rsrc, in_imm8);
  assign in_ready = !Reset && !Flush && (level_q != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign issue    = !Stall && (level_q != '0);

`ifdef INSTR_ENCODER_REPEAT_EN
  logic [3:0] rep_mem [DEPTH];
  logic [3:0] rep_left;
  logic       rep_active;
  logic [3:0] rep_eff;

  // Remaining repeats for the head: freshly loaded from the entry until its first issue.
  assign rep_eff = rep_active ? rep_left : rep_mem[rd_ptr];
  assign pop     = issue && (rep_eff == 4'd0);

  always_ff @(posedge Clock) begin
    if (push) rep_mem[wr_ptr] <= in_repeat;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rep_left   <= 4'd0;
      rep_active <= 1'b0;
    end else if (Flush) begin
      rep_left   <= 4'd0;
      rep_active <= 1'b0;
    end else if (issue) begin
      if (pop) begin
        rep_left   <= 4'd0;
        rep_active <= 1'b0;
      end else begin
        rep_left   <= rep_eff - 4'd1;
        rep_active <= 1'b1;
      end
    end
  end
`else
  assign pop = issue;
`endif

  // Stage p0: FIFO write of the packed word
  always_ff @(posedge Clock) begin
    if (push) mem_p0[wr_ptr] <= word_p0;
  end

  // Stage p1: pointers, occupancy and the issue register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      instr_p1 <= NOP_WORD;
      vld_p1   <= 1'b0;
    end else if (Flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      instr_p1 <= NOP_WORD;
      vld_p1   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (issue) begin
        instr_p1 <= mem_p0[rd_ptr];
        vld_p1   <= 1'b1;
      end else begin
        instr_p1 <= NOP_WORD;
        vld_p1   <= 1'b0;
      end
    end
  end

  assign Instruction = instr_p1;
  assign InstrValid  = vld_p1;
  assign Level       = level_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder: latency, stall, full/refill, flush, async reset
// and (with INSTR_ENCODER_REPEAT_EN) per-entry repeat issue.
module tb_instr_encoder;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_imm;
  logic [3:0]  in_op;
  logic [3:0]  in_rdest;
  logic [3:0]  in_ext;
  logic [3:0]  in_rsrc;
  logic [7:0]  in_imm8;
`ifdef INSTR_ENCODER_REPEAT_EN
  logic [3:0]  in_repeat;
`endif
  logic        Stall;
  logic        Flush;
  logic [15:0] Instruction;
  logic        InstrValid;
  logic [2:0]  Level;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [15:0] NOP = 16'h00D0;

  instr_encoder #(.DEPTH(4), .NOP_WORD(16'h00D0)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_imm      (in_imm),
    .in_op       (in_op),
    .in_rdest    (in_rdest),
    .in_ext      (in_ext),
    .in_rsrc     (in_rsrc),
    .in_imm8     (in_imm8),
`ifdef INSTR_ENCODER_REPEAT_EN
    .in_repeat   (in_repeat),
`endif
    .Stall       (Stall),
    .Flush       (Flush),
    .Instruction (Instruction),
    .InstrValid  (InstrValid),
    .Level       (Level)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Fields not used by the chosen format are driven with the inverse so a format mix-up shows.
  task automatic drive(input logic imm, input logic [15:0] w);
    in_imm   = imm;
    in_op    = w[15:12];
    in_rdest = w[11:8];
    if (imm) begin
      in_imm8 = w[7:0];
      in_ext  = ~w[7:4];
      in_rsrc = ~w[3:0];
    end else begin
      in_ext  = w[7:4];
      in_rsrc = w[3:0];
      in_imm8 = ~w[7:0];
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] w, input logic v, input logic [2:0] lvl);
    check({tag, "_instr"}, {16'b0, Instruction}, {16'b0, w});
    check({tag, "_vld"}, {31'b0, InstrValid}, {31'b0, v});
    check({tag, "_level"}, {29'b0, Level}, {29'b0, lvl});
  endtask

  initial begin
    Reset = 1'b1; in_valid = 1'b0; Stall = 1'b0; Flush = 1'b0;
    in_imm = 1'b0; in_op = '0; in_rdest = '0; in_ext = '0; in_rsrc = '0; in_imm8 = '0;
`ifdef INSTR_ENCODER_REPEAT_EN
    in_repeat = 4'd0;
`endif
    tick(); tick();
    Reset = 1'b0;
    tick();
    expect_out("reset", NOP, 1'b0, 3'd0);
    check("reset_ready", {31'b0, in_ready}, 32'd1);

    // Register ADD: accepted at edge N, issued after edge N+1
    drive(1'b0, 16'h0357); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    expect_out("lat_n", NOP, 1'b0, 3'd1);
    tick();
    expect_out("lat_n1", 16'h0357, 1'b1, 3'd0);
    tick();
    expect_out("lat_idle", NOP, 1'b0, 3'd0);

    // Immediate word held under stall for three cycles
    Stall = 1'b1;
    drive(1'b1, 16'h52F0); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    expect_out("stall_hold", NOP, 1'b0, 3'd1);
    Stall = 1'b0;
    tick();
    expect_out("stall_rel", 16'h52F0, 1'b1, 3'd0);

    // Fill to DEPTH under stall; a fifth request must be refused
    Stall = 1'b1;
    in_valid = 1'b1;
    drive(1'b0, 16'h1123); tick();
    drive(1'b1, 16'h24A5); tick();
    drive(1'b0, 16'hFEDC); tick();
    drive(1'b1, 16'h7001); tick();
    check("full_level", {29'b0, Level}, 32'd4);
    check("full_ready", {31'b0, in_ready}, 32'd0);
    drive(1'b0, 16'h3986); tick();
    check("full_no_push", {29'b0, Level}, 32'd4);
    Stall = 1'b0;
    tick();
    expect_out("drain0", 16'h1123, 1'b1, 3'd3);
    check("drain0_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    expect_out("drain1_pushpop", 16'h24A5, 1'b1, 3'd3);
    tick();
    expect_out("drain2", 16'hFEDC, 1'b1, 3'd2);
    tick();
    expect_out("drain3", 16'h7001, 1'b1, 3'd1);
    tick();
    expect_out("drain4_wrap", 16'h3986, 1'b1, 3'd0);
    tick();
    expect_out("drain_idle", NOP, 1'b0, 3'd0);

    // Back-to-back refill across the wrapped pointers
    in_valid = 1'b1;
    drive(1'b1, 16'hA1B2); tick();
    drive(1'b0, 16'hC4D5); tick();
    in_valid = 1'b0;
    expect_out("refill0", 16'hA1B2, 1'b1, 3'd1);
    tick();
    expect_out("refill1", 16'hC4D5, 1'b1, 3'd0);

    // Flush at Level 3 together with a valid request
    Stall = 1'b1;
    in_valid = 1'b1;
    drive(1'b0, 16'h1111); tick();
    drive(1'b0, 16'h2222); tick();
    drive(1'b0, 16'h3333); tick();
    check("pre_flush_level", {29'b0, Level}, 32'd3);
    drive(1'b0, 16'h4444); Flush = 1'b1;
    #1;
    check("flush_ready", {31'b0, in_ready}, 32'd0);
    tick();
    Flush = 1'b0; in_valid = 1'b0;
    expect_out("flush", NOP, 1'b0, 3'd0);
    Stall = 1'b0;
    tick();
    expect_out("flush_empty", NOP, 1'b0, 3'd0);

    // Asynchronous reset between edges while a real word is on the output
    Stall = 1'b1;
    in_valid = 1'b1;
    drive(1'b1, 16'h6789); tick();
    drive(1'b1, 16'h9ABC); tick();
    in_valid = 1'b0; Stall = 1'b0;
    tick();
    expect_out("pre_reset", 16'h6789, 1'b1, 3'd1);
    #2 Reset = 1'b1;
    #1;
    expect_out("async_reset", NOP, 1'b0, 3'd0);
    check("async_reset_ready", {31'b0, in_ready}, 32'd0);
    #1 Reset = 1'b0;
    tick();
    expect_out("post_reset", NOP, 1'b0, 3'd0);
    check("post_reset_ready", {31'b0, in_ready}, 32'd1);

`ifdef INSTR_ENCODER_REPEAT_EN
    // Repeat 2: three non-stalled issues with a stall cycle in between
    drive(1'b0, 16'h1234); in_repeat = 4'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_repeat = 4'd0;
    tick();
    expect_out("rep0", 16'h1234, 1'b1, 3'd1);
    Stall = 1'b1;
    tick();
    expect_out("rep_stall", NOP, 1'b0, 3'd1);
    Stall = 1'b0;
    tick();
    expect_out("rep1", 16'h1234, 1'b1, 3'd1);
    tick();
    expect_out("rep2", 16'h1234, 1'b1, 3'd0);
    tick();
    expect_out("rep_done", NOP, 1'b0, 3'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
